seq_addsub_nbit: RTL and testbench
==================================

Name: seq_addsub_nbit

Overview:
- Parametrised multi-cycle adder/subtractor that succeeds the combinational 4-bit adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, ripple-carrying between chunks.
- Uses a start/busy/done handshake.
- Used in the ALU datapath where wide operands must not close timing in one cycle; also produces carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per RUN cycle; N = WIDTH/CHUNK cycles per operation; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only when busy=0.
- Sub  input  1  0 = add, 1 = subtract; latched with start.
- FA  input  WIDTH  operand A; latched with start.
- FB  input  WIDTH  operand B; latched with start.
- Cin  input  1  carry-in (add) / borrow-in (sub); latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when results become valid.
- Sum  output  WIDTH  result, registered.
- Cout  output  1  carry out of bit WIDTH-1, raw adder carry.
- Ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - busy, done, Sum, Cout and Ovf all go to 0.
  - Internal chunk index, partial sum and carry are cleared.
  - rst overrides start and any in-flight operation.
- Arithmetic:
  - Effective B' = Sub ? ~FB : FB.
  - Effective carry-in c0 = Sub ? ~Cin : Cin.
  - Result = FA + B' + c0, mod 2^WIDTH.
  - Add is FA+FB+Cin; subtract is FA-FB-Cin.
  - Cout is the raw carry out in both modes, so in sub mode Cout=1 means no borrow.
  - Ovf = (A[msb]==B'[msb]) && (Sum[msb]!=A[msb]).
- State machine (IDLE, RUN, DONE):
  - IDLE: busy=0, done=0. start=1 at edge E0 latches FA, FB, Sub and Cin, sets idx=0 and carry=c0, and moves to RUN.
  - RUN: busy=1. Each edge adds chunk idx (bits idx*CHUNK +: CHUNK) of A and B' plus carry, stores that chunk of the partial sum and the new carry, then increments idx.
  - RUN exit: on the edge processing idx=N-1 (edge EN), Sum, Cout and Ovf are loaded from the completed result and the state moves to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accepted).
- Timing:
  - Latency: done is high in the cycle following EN, i.e. N clocks after the start-capture edge.
  - busy is high for exactly N cycles.
  - Throughput: one operation per N+1 cycles.
- Output stability: Sum, Cout and Ovf change only at EN or on reset. They hold the previous result throughout RUN and after done, until the next completion.
- Input handling:
  - start while busy=1 is ignored; it is neither queued nor able to corrupt the operation.
  - Operand inputs may change freely after E0.
- Degenerate case CHUNK=WIDTH (N=1): one RUN cycle, done two edges after start. The handshake is identical.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs cleared.

Test Plan:
- Reset check: assert rst with start=1 and nonzero operands → Sum=0, Cout=0, Ovf=0, busy=0, done=0; no operation starts.
- Addition (WIDTH=16, CHUNK=4):
  - 0x00FF+0x0001, Cin=0 → Sum=0x0100, Cout=0, Ovf=0.
  - busy high for exactly 4 cycles; done pulses 1 cycle, 4 clocks after the start edge.
- Add boundaries:
  - 0xFFFF+0x0001, Cin=0 → Sum=0x0000, Cout=1, Ovf=0.
  - 0x7FFF+0x0000, Cin=1 → Sum=0x8000, Cout=0, Ovf=1.
- Subtract:
  - Sub=1, 0x0005-0x0007, Cin=0 → Sum=0xFFFE, Cout=0, Ovf=0.
  - Sub=1, 0x8000-0x0001, Cin=0 → Sum=0x7FFF, Cout=1, Ovf=1.
  - Sub=1, 0x0003-0x0001, Cin=1 → Sum=0x0001, Cout=1.
- Handshake edge cases:
  - start pulsed during RUN → ignored; result matches the first operands.
  - start in the DONE cycle → second operation accepted; done pulses again N+1 cycles later.
  - rst in the 2nd RUN cycle → no done pulse, outputs cleared.
- Exhaustive check: WIDTH=4 with CHUNK=1 and with CHUNK=4, all FA, FB, Cin and Sub combinations (1024), compared against a behavioural model (Sum, Cout, Ovf); done latency checked as N each time.

Source files
------------

// File: rtl/seq_addsub_nbit.sv
// Multi-cycle WIDTH-bit adder/subtractor: adds CHUNK bits per clock with a
// rippled carry, using a start/busy/done handshake. Also reports carry-out and signed overflow.
module seq_addsub_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] FA,
  input  logic [WIDTH-1:0] FB,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;          // B already inverted for subtract
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last;
  int               base;
  logic [CHUNK:0]   chunk_sum;

  // A new operation may be captured from IDLE or from the DONE cycle, never during RUN.
  assign accept    = start && (state_q != S_RUN);
  assign last      = (state_q == S_RUN) && (idx_q == LAST_IDX);
  assign base      = int'(idx_q) * CHUNK;
  assign chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every next-state value defaults to its register first; without
    // this any path that skips an assignment would infer a latch.
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = FA;
      b_d     = Sub ? ~FB : FB;
      carry_d = Sub ^ Cin;
      idx_d   = '0;
    end else if (state_q == S_RUN) begin
      psum_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
      carry_d = chunk_sum[CHUNK];
      idx_d   = idx_q + IDX_W'(1);
      if (last) begin
        sum_d  = psum_d;
        cout_d = chunk_sum[CHUNK];
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (psum_d[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    Sum  = sum_q;
    Cout = cout_q;
    Ovf  = ovf_q;
  end

endmodule

// File: tb/tb_seq_addsub_nbit.sv
// Directed bench for seq_addsub_nbit: a 16-bit/4-bit-chunk instance plus two
// 4-bit instances (CHUNK=1 and CHUNK=4) swept over every input combination.
module tb_seq_addsub_nbit;

  localparam int N16 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        s16_start, s16_sub, s16_cin;
  logic [15:0] s16_a, s16_b;
  logic        d16_busy, d16_done, d16_cout, d16_ovf;
  logic [15:0] d16_sum;

  logic       s4_start1, s4_start4, s4_sub, s4_cin;
  logic [3:0] s4_a, s4_b;
  logic       d4a_busy, d4a_done, d4a_cout, d4a_ovf;
  logic [3:0] d4a_sum;
  logic       d4b_busy, d4b_done, d4b_cout, d4b_ovf;
  logic [3:0] d4b_sum;

  seq_addsub_nbit #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(s16_start), .Sub(s16_sub), .FA(s16_a), .FB(s16_b),
    .Cin(s16_cin), .busy(d16_busy), .done(d16_done), .Sum(d16_sum), .Cout(d16_cout),
    .Ovf(d16_ovf));

  seq_addsub_nbit #(.WIDTH(4), .CHUNK(1)) dut4a (
    .clk(clk), .rst(rst), .start(s4_start1), .Sub(s4_sub), .FA(s4_a), .FB(s4_b),
    .Cin(s4_cin), .busy(d4a_busy), .done(d4a_done), .Sum(d4a_sum), .Cout(d4a_cout),
    .Ovf(d4a_ovf));

  seq_addsub_nbit #(.WIDTH(4), .CHUNK(4)) dut4b (
    .clk(clk), .rst(rst), .start(s4_start4), .Sub(s4_sub), .FA(s4_a), .FB(s4_b),
    .Cin(s4_cin), .busy(d4b_busy), .done(d4b_done), .Sum(d4b_sum), .Cout(d4b_cout),
    .Ovf(d4b_ovf));

  typedef struct {
    logic        sub;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] sum;
    logic        cout, ovf;
  } vec_t;

  // Runs one 16-bit operation from a negedge; k counts sample points after the
  // capture edge, so done is expected at k = N and busy for N samples.
  task automatic run16(input logic sub, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, output logic [15:0] sum, output logic cout,
                       output logic ovf, output int done_k, output int busy_cnt,
                       output int done_cnt);
    s16_start = 1'b1; s16_sub = sub; s16_a = a; s16_b = b; s16_cin = cin;
    @(posedge clk);
    @(negedge clk);
    s16_start = 1'b0; s16_a = ~a; s16_b = ~b; s16_sub = ~sub; s16_cin = ~cin;
    done_k = -1; busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k <= N16 + 3; k++) begin
      if (k > 0) @(negedge clk);
      if (d16_busy) busy_cnt++;
      if (d16_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
    end
    sum = d16_sum; cout = d16_cout; ovf = d16_ovf;
  endtask

  task automatic run4(input bit chunk4, input logic sub, input logic [3:0] a,
                      input logic [3:0] b, input logic cin, output logic [3:0] sum,
                      output logic cout, output logic ovf, output int done_k);
    int n;
    n = chunk4 ? 1 : 4;
    s4_sub = sub; s4_a = a; s4_b = b; s4_cin = cin;
    if (chunk4) s4_start4 = 1'b1; else s4_start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s4_start1 = 1'b0; s4_start4 = 1'b0;
    done_k = -1;
    for (int k = 0; k <= n + 2; k++) begin
      if (k > 0) @(negedge clk);
      if ((chunk4 ? d4b_done : d4a_done) && done_k < 0) done_k = k;
    end
    sum  = chunk4 ? d4b_sum  : d4a_sum;
    cout = chunk4 ? d4b_cout : d4a_cout;
    ovf  = chunk4 ? d4b_ovf  : d4a_ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s16_start = 1'b1; s16_sub = 1'b0; s16_a = 16'h1234; s16_b = 16'h4321; s16_cin = 1'b1;
    s4_start1 = 1'b1; s4_start4 = 1'b1; s4_sub = 1'b0; s4_a = 4'h5; s4_b = 4'h6; s4_cin = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({d16_sum, d16_cout, d16_ovf, d16_busy, d16_done} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               d16_sum, d16_cout, d16_ovf, d16_busy, d16_done);
    end
    rst = 1'b0; s16_start = 1'b0; s4_start1 = 1'b0; s4_start4 = 1'b0;
    @(negedge clk);
    checks++;
    if ({d16_busy, d16_done, d4a_busy, d4b_busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_no_start: got busy=%b done=%b busy4a=%b busy4b=%b, want 0",
               d16_busy, d16_done, d4a_busy, d4b_busy);
    end
  endtask

  task automatic test_add();
    logic [15:0] sum; logic cout, ovf; int dk, bc, dc;
    run16(1'b0, 16'h00FF, 16'h0001, 1'b0, sum, cout, ovf, dk, bc, dc);
    checks++;
    if ({sum, cout, ovf} !== {16'h0100, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_basic: got sum=%h cout=%b ovf=%b, want 0100 0 0", sum, cout, ovf);
    end
    checks++;
    if (dk !== N16 || bc !== N16 || dc !== 1) begin
      errors++;
      $display("FAIL add_timing: got done_k=%0d busy_cycles=%0d done_pulses=%0d, want 4 4 1",
               dk, bc, dc);
    end
  endtask

  task automatic test_vectors();
    vec_t v[5];
    logic [15:0] sum; logic cout, ovf; int dk, bc, dc;
    v[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[1] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    v[2] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    v[3] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    v[4] = '{1'b1, 16'h0003, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run16(v[i].sub, v[i].a, v[i].b, v[i].cin, sum, cout, ovf, dk, bc, dc);
      checks++;
      if ({sum, cout, ovf} !== {v[i].sum, v[i].cout, v[i].ovf} || dk !== N16) begin
        errors++;
        $display("FAIL vector_%0d: got sum=%h cout=%b ovf=%b done_k=%0d, want %h %b %b 4",
                 i, sum, cout, ovf, dk, v[i].sum, v[i].cout, v[i].ovf);
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [15:0] prev; int dk, dc; bit held;
    prev = d16_sum; held = 1'b1;
    s16_start = 1'b1; s16_sub = 1'b0; s16_a = 16'h1234; s16_b = 16'h1111; s16_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s16_start = 1'b0;
    dk = -1; dc = 0;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        s16_start = 1'b1; s16_sub = 1'b1; s16_a = 16'hFFFF; s16_b = 16'hAAAA; s16_cin = 1'b1;
      end
      if (k == 2) s16_start = 1'b0;
      if (k < N16 && d16_sum !== prev) held = 1'b0;
      if (d16_done) begin
        dc++;
        if (dk < 0) dk = k;
      end
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL sum_hold_during_run: got sum changed before done, want %h held", prev);
    end
    checks++;
    if ({d16_sum, d16_cout, d16_ovf} !== {16'h2345, 1'b0, 1'b0} || dk !== N16 || dc !== 1) begin
      errors++;
      $display("FAIL start_ignored: got sum=%h cout=%b ovf=%b done_k=%0d pulses=%0d, want 2345 0 0 4 1",
               d16_sum, d16_cout, d16_ovf, dk, dc);
    end
  endtask

  task automatic test_back_to_back();
    int dk1, dk2; logic [15:0] first;
    s16_start = 1'b1; s16_sub = 1'b0; s16_a = 16'h0010; s16_b = 16'h0020; s16_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s16_start = 1'b0;
    dk1 = -1; dk2 = -1; first = 'x;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      if (d16_done) begin
        if (dk1 < 0) begin
          dk1 = k; first = d16_sum;
        end else if (dk2 < 0) dk2 = k;
      end
      if (k == N16) begin
        s16_start = 1'b1; s16_sub = 1'b1; s16_a = 16'h0100; s16_b = 16'h0001; s16_cin = 1'b0;
      end
      if (k == N16 + 1) s16_start = 1'b0;
    end
    checks++;
    if (first !== 16'h0030 || dk1 !== N16) begin
      errors++;
      $display("FAIL b2b_first: got sum=%h done_k=%0d, want 0030 4", first, dk1);
    end
    checks++;
    if ({d16_sum, d16_cout, d16_ovf} !== {16'h00FF, 1'b1, 1'b0} || dk2 !== 2 * N16 + 1) begin
      errors++;
      $display("FAIL b2b_second: got sum=%h cout=%b ovf=%b done_k=%0d, want 00FF 1 0 9",
               d16_sum, d16_cout, d16_ovf, dk2);
    end
  endtask

  task automatic test_reset_mid_run();
    int dc; bit quiet;
    s16_start = 1'b1; s16_sub = 1'b0; s16_a = 16'h0F0F; s16_b = 16'h0101; s16_cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s16_start = 1'b0;
    dc = 0; quiet = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) rst = 1'b1;
      if (k == 2) begin
        rst = 1'b0;
        checks++;
        if ({d16_sum, d16_cout, d16_ovf, d16_busy, d16_done} !== 20'h0) begin
          errors++;
          $display("FAIL reset_mid_run: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
                   d16_sum, d16_cout, d16_ovf, d16_busy, d16_done);
        end
      end
      if (d16_done) dc++;
      if (k > 2 && (d16_busy || d16_sum !== 16'h0)) quiet = 1'b0;
    end
    checks++;
    if (dc !== 0 || !quiet) begin
      errors++;
      $display("FAIL reset_abort: got done_pulses=%0d idle_quiet=%b, want 0 1", dc, quiet);
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] sum, bp, esum; logic cout, ovf; logic [4:0] r; int dk;
    for (int sel = 0; sel < 2; sel++) begin
      for (int op = 0; op < 1024; op++) begin
        logic sub, cin; logic [3:0] a, b; logic c0;
        sub = op[9]; cin = op[8]; a = op[7:4]; b = op[3:0];
        bp = sub ? ~b : b;
        c0 = sub ^ cin;
        r = {1'b0, a} + {1'b0, bp} + {4'b0, c0};
        esum = r[3:0];
        run4(sel[0], sub, a, b, cin, sum, cout, ovf, dk);
        checks++;
        if ({sum, cout, ovf} !== {esum, r[4], (a[3] == bp[3]) && (esum[3] != a[3])}
            || dk !== (sel ? 1 : 4)) begin
          errors++;
          $display("FAIL exh_chunk%0d sub=%b a=%h b=%h cin=%b: got sum=%h cout=%b ovf=%b done_k=%0d, want %h %b %b %0d",
                   sel ? 4 : 1, sub, a, b, cin, sum, cout, ovf, dk, esum, r[4],
                   (a[3] == bp[3]) && (esum[3] != a[3]), sel ? 1 : 4);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_vectors();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
